// File: rtl/wb_bus_splitter_wd.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_splitter_wd
// Purpose  : Wishbone B4 classic 1-to-N bus splitter with registered
//            slave-side outputs, a per-transaction watchdog and sticky
//            error reporting (last error source and kind).
// Ports    :
//   wb_clk_i / wb_rst_n         clock, synchronous active-low reset
//   m_wb_*_i                    master request (adr, dat, sel, we, cyc, stb)
//   m_wb_dat_o/ack_o/err_o      master response; data is 0 outside ack
//   s_wb_cyc/stb/we_o           per-slave controls, one bit per slave
//   s_wb_sel/adr/dat_o          per-slave request fields, slice k per slave
//   s_wb_dat/ack/err_i          per-slave responses
//   timeout_o                   one-cycle pulse when the watchdog fires
//   err_idx_o / err_kind_o      index and kind of the last error (sticky)
//                               kind: 00 none, 01 unmapped, 10 slave err,
//                               11 timeout
// Revision : 1.0 - initial release
// ============================================================================
module wb_bus_splitter_wd #(
    parameter int NUM_PERIPHERALS  = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SEL_WIDTH        = 4,
    parameter int ADDR_SEL_LOW_BIT = 16,
    parameter int IDX_W            = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_n,
    input  logic [ADDR_WIDTH-1:0]                 m_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]                 m_wb_dat_i,
    input  logic [SEL_WIDTH-1:0]                  m_wb_sel_i,
    input  logic                                  m_wb_we_i,
    input  logic                                  m_wb_cyc_i,
    input  logic                                  m_wb_stb_i,
    output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
    output logic                                  m_wb_ack_o,
    output logic                                  m_wb_err_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
    output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
    output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
    input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i,
    output logic                                  timeout_o,
    output logic [IDX_W-1:0]                      err_idx_o,
    output logic [1:0]                            err_kind_o
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    localparam logic [1:0] c_KIND_UNMAPPED = 2'b01;
    localparam logic [1:0] c_KIND_SLV_ERR  = 2'b10;
    localparam logic [1:0] c_KIND_TIMEOUT  = 2'b11;

    // A zero timeout disables the watchdog; keep the counter at least 1 bit
    // wide so the design still elaborates in that configuration.
    localparam bit c_WD_EN = (TIMEOUT_CYCLES != 0);
    localparam int c_CNT_W = c_WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WD_LAST =
        c_CNT_W'(c_WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [c_CNT_W-1:0] r_wd_cnt;

    logic [IDX_W-1:0]                     w_req_idx;
    logic [31:0]                          w_req_idx_ext;
    logic [NUM_PERIPHERALS-1:0]           w_req_onehot;
    logic [NUM_PERIPHERALS*SEL_WIDTH-1:0] w_req_sel;
    logic                                 w_req_mapped;
    logic                                 w_sel_ack;
    logic                                 w_sel_err;
    logic [DATA_WIDTH-1:0]                w_sel_dat;
    logic                                 w_wd_expire;
    logic                                 w_leave;

    assign w_req_idx     = m_wb_adr_i[ADDR_SEL_LOW_BIT +: IDX_W];
    assign w_req_idx_ext = 32'(w_req_idx);

    // Request decode, plus response selection. In ACTIVE the registered
    // strobe vector is exactly the one-hot of the latched index, so it
    // doubles as the response mux select and masks non-selected slaves.
    always_comb begin
        w_req_onehot = '0;
        w_req_sel    = '0;
        w_sel_dat    = '0;
        for (int k = 0; k < NUM_PERIPHERALS; k++) begin
            if (w_req_idx_ext == k) begin
                w_req_onehot[k]                      = 1'b1;
                w_req_sel[k*SEL_WIDTH +: SEL_WIDTH] = m_wb_sel_i;
            end
            if (s_wb_stb_o[k]) begin
                w_sel_dat = s_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_req_mapped = |w_req_onehot;
    assign w_sel_ack    = |(s_wb_ack_i & s_wb_stb_o);
    assign w_sel_err    = |(s_wb_err_i & s_wb_stb_o);
    assign w_wd_expire  = c_WD_EN && (r_wd_cnt == c_WD_LAST);
    assign w_leave      = !m_wb_cyc_i || w_sel_err || w_sel_ack || w_wd_expire;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= '0;
            r_wd_cnt   <= '0;
            m_wb_dat_o <= '0;
            m_wb_ack_o <= 1'b0;
            m_wb_err_o <= 1'b0;
            s_wb_cyc_o <= '0;
            s_wb_stb_o <= '0;
            s_wb_we_o  <= '0;
            s_wb_sel_o <= '0;
            s_wb_adr_o <= '0;
            s_wb_dat_o <= '0;
            timeout_o  <= 1'b0;
            err_idx_o  <= '0;
            err_kind_o <= '0;
        end else begin
            // Response outputs are single-cycle pulses.
            m_wb_ack_o <= 1'b0;
            m_wb_err_o <= 1'b0;
            m_wb_dat_o <= '0;
            timeout_o  <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (m_wb_cyc_i && m_wb_stb_i) begin
                        r_idx      <= w_req_idx;
                        s_wb_adr_o <= {NUM_PERIPHERALS{m_wb_adr_i}};
                        s_wb_dat_o <= {NUM_PERIPHERALS{m_wb_dat_i}};
                        if (w_req_mapped) begin
                            r_state    <= c_ST_ACTIVE;
                            r_wd_cnt   <= '0;
                            s_wb_cyc_o <= w_req_onehot;
                            s_wb_stb_o <= w_req_onehot;
                            s_wb_we_o  <= m_wb_we_i ? w_req_onehot : '0;
                            s_wb_sel_o <= w_req_sel;
                        end else begin
                            r_state    <= c_ST_RESP;
                            m_wb_err_o <= 1'b1;
                            err_idx_o  <= w_req_idx;
                            err_kind_o <= c_KIND_UNMAPPED;
                        end
                    end
                end

                c_ST_ACTIVE: begin
                    if (!m_wb_cyc_i) begin
                        // Master abort: silent return, error state untouched.
                        r_state <= c_ST_IDLE;
                    end else if (w_sel_err) begin
                        r_state    <= c_ST_RESP;
                        m_wb_err_o <= 1'b1;
                        err_idx_o  <= r_idx;
                        err_kind_o <= c_KIND_SLV_ERR;
                    end else if (w_sel_ack) begin
                        r_state    <= c_ST_RESP;
                        m_wb_ack_o <= 1'b1;
                        m_wb_dat_o <= w_sel_dat;
                    end else if (w_wd_expire) begin
                        r_state    <= c_ST_RESP;
                        m_wb_err_o <= 1'b1;
                        timeout_o  <= 1'b1;
                        err_idx_o  <= r_idx;
                        err_kind_o <= c_KIND_TIMEOUT;
                    end else if (r_wd_cnt != '1) begin
                        r_wd_cnt <= r_wd_cnt + c_CNT_W'(1);
                    end

                    if (w_leave) begin
                        s_wb_cyc_o <= '0;
                        s_wb_stb_o <= '0;
                        s_wb_we_o  <= '0;
                        s_wb_sel_o <= '0;
                    end
                end

                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state    <= c_ST_IDLE;
                    s_wb_cyc_o <= '0;
                    s_wb_stb_o <= '0;
                    s_wb_we_o  <= '0;
                    s_wb_sel_o <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_splitter_wd.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bus_splitter_wd
// Purpose  : Self-checking bench for wb_bus_splitter_wd (3 slaves, 8-cycle
//            watchdog): directed vector table, hand-written abort/reset
//            sequences and randomized transactions against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bus_splitter_wd;

    localparam int NP  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int LOW = 16;
    localparam int IW  = 4;
    localparam int TO  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [AW-1:0]     m_adr;
    logic [DW-1:0]     m_dat;
    logic [SW-1:0]     m_sel;
    logic              m_we, m_cyc, m_stb;
    logic [DW-1:0]     m_rdat;
    logic              m_ack, m_err;
    logic [NP-1:0]     s_cyc, s_stb, s_we;
    logic [NP*SW-1:0]  s_sel;
    logic [NP*AW-1:0]  s_adr;
    logic [NP*DW-1:0]  s_dat_o;
    logic [NP*DW-1:0]  s_dat_i;
    logic [NP-1:0]     s_ack, s_err;
    logic              tmo;
    logic [IW-1:0]     eidx;
    logic [1:0]        ekind;

    wb_bus_splitter_wd #(
        .NUM_PERIPHERALS (NP),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .SEL_WIDTH       (SW),
        .ADDR_SEL_LOW_BIT(LOW),
        .IDX_W           (IW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .m_wb_adr_i(m_adr),
        .m_wb_dat_i(m_dat),
        .m_wb_sel_i(m_sel),
        .m_wb_we_i (m_we),
        .m_wb_cyc_i(m_cyc),
        .m_wb_stb_i(m_stb),
        .m_wb_dat_o(m_rdat),
        .m_wb_ack_o(m_ack),
        .m_wb_err_o(m_err),
        .s_wb_cyc_o(s_cyc),
        .s_wb_stb_o(s_stb),
        .s_wb_we_o (s_we),
        .s_wb_sel_o(s_sel),
        .s_wb_adr_o(s_adr),
        .s_wb_dat_o(s_dat_o),
        .s_wb_dat_i(s_dat_i),
        .s_wb_ack_i(s_ack),
        .s_wb_err_i(s_err),
        .timeout_o (tmo),
        .err_idx_o (eidx),
        .err_kind_o(ekind)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Slave behaviour: respond on strobe cycle slv_delay (0 = never);
    // mode 0 ack, 1 err, 2 ack+err together.
    int          slv_delay [NP];
    int          slv_mode  [NP];
    logic [DW-1:0] slv_rdata [NP];
    int          slv_cnt   [NP];
    bit          noise_en;

    // Model of the sticky error registers.
    logic [1:0]    exp_kind;
    logic [IW-1:0] exp_idx;

    typedef struct {
        int          resp;      // 0 none, 1 ack, 2 err, 3 both
        int          lat;
        int          strobes;
        int          other;
        int          bad;
        int          tmo_cnt;
        int          dat_nz;
        int          extra;
        logic [DW-1:0] rdata;
    } obs_t;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic          we;
        int            delay;
        int            mode;
        logic [DW-1:0] rdata;
        int            e_resp;
        int            e_lat;
        int            e_str;
        int            e_tmo;
        logic [1:0]    e_kind;
        logic [IW-1:0] e_idx;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_update();
        for (int k = 0; k < NP; k++) begin
            bit hit;
            if (s_stb[k]) slv_cnt[k]++;
            else          slv_cnt[k] = 0;
            s_dat_i[k*DW +: DW] = slv_rdata[k];
            hit = s_stb[k] && (slv_delay[k] != 0) && (slv_cnt[k] == slv_delay[k]);
            if (s_stb[k]) begin
                s_ack[k] = hit && (slv_mode[k] != 1);
                s_err[k] = hit && (slv_mode[k] != 0);
            end else begin
                s_ack[k] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                s_err[k] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic run_txn(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel, input logic we, output obs_t o);
        int  tgt;
        bit  done;
        o = '{default: 0};
        tgt   = int'(adr[LOW +: IW]);
        m_adr = adr; m_dat = dat; m_sel = sel; m_we = we;
        m_cyc = 1'b1; m_stb = 1'b1;
        done  = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            slave_update();
            for (int k = 0; k < NP; k++) begin
                if (k == tgt) begin
                    if (s_stb[k]) begin
                        o.strobes++;
                        if (s_cyc[k] !== 1'b1 || s_we[k] !== we ||
                            s_sel[k*SW +: SW] !== sel || s_adr[k*AW +: AW] !== adr ||
                            s_dat_o[k*DW +: DW] !== dat) o.bad++;
                    end else if (s_cyc[k]) begin
                        o.bad++;
                    end
                end else begin
                    if (s_cyc[k] || s_stb[k]) o.other++;
                    if (s_we[k] || (s_sel[k*SW +: SW] != '0)) o.bad++;
                end
            end
            if (tmo) o.tmo_cnt++;
            if (!m_ack && m_rdat != '0) o.dat_nz++;
            if (m_ack || m_err) begin
                o.resp  = (m_ack && m_err) ? 3 : (m_ack ? 1 : 2);
                o.lat   = c;
                o.rdata = m_rdat;
                done    = 1'b1;
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        @(negedge clk);
        slave_update();
        if (m_ack || m_err || tmo) o.extra++;
        if ((s_cyc | s_stb) != '0) o.extra++;
        if (m_rdat != '0) o.dat_nz++;
    endtask

    task automatic check_obs(input string tag, input obs_t o, input int e_resp,
                             input int e_lat, input int e_str, input int e_tmo,
                             input logic [DW-1:0] e_rdata, input logic [1:0] e_kind,
                             input logic [IW-1:0] e_idx);
        chk({tag, ".resp"},     o.resp,    e_resp);
        chk({tag, ".latency"},  o.lat,     e_lat);
        chk({tag, ".strobes"},  o.strobes, e_str);
        chk({tag, ".timeout"},  o.tmo_cnt, e_tmo);
        chk({tag, ".other_stb"}, o.other,  0);
        chk({tag, ".fields"},   o.bad,     0);
        chk({tag, ".dat_idle"}, o.dat_nz,  0);
        chk({tag, ".after"},    o.extra,   0);
        if (e_resp == 1) chk({tag, ".rdata"}, o.rdata, e_rdata);
        chk({tag, ".err_kind"}, ekind, e_kind);
        chk({tag, ".err_idx"},  eidx,  e_idx);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".s_ctl"},  {s_cyc, s_stb, s_we}, '0);
        chk({tag, ".s_sel"},  s_sel, '0);
        chk({tag, ".s_adr"},  s_adr, '0);
        chk({tag, ".s_dat"},  s_dat_o, '0);
        chk({tag, ".m_resp"}, {m_ack, m_err, tmo}, '0);
        chk({tag, ".m_dat"},  m_rdat, '0);
        chk({tag, ".err"},    {eidx, ekind}, '0);
    endtask

    task automatic config_slave(input int tgt, input int delay, input int mode,
                                input logic [DW-1:0] rdata);
        for (int k = 0; k < NP; k++) begin
            slv_delay[k] = 0;
            slv_mode[k]  = 0;
        end
        if (tgt < NP) begin
            slv_delay[tgt] = delay;
            slv_mode[tgt]  = mode;
            slv_rdata[tgt] = rdata;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs[11];
        obs_t o;
        int   seen;

        rst_n = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
        m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        s_dat_i = '0; s_ack = '0; s_err = '0; noise_en = 1'b0;
        for (int k = 0; k < NP; k++) begin
            slv_delay[k] = 0; slv_mode[k] = 0; slv_rdata[k] = '0; slv_cnt[k] = 0;
        end
        exp_kind = 2'b00; exp_idx = '0;

        vecs[0]  = '{32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1, 0, 32'hCAFE_F00D, 1, 2, 1, 0, 2'b00, 4'd0};
        vecs[1]  = '{32'h0001_0004, 32'h0000_0000, 4'hF, 1'b0, 1, 0, 32'hCAFE_F00D, 1, 2, 1, 0, 2'b00, 4'd0};
        vecs[2]  = '{32'h0000_0010, 32'h1111_2222, 4'h3, 1'b0, 3, 0, 32'h1234_5678, 1, 4, 3, 0, 2'b00, 4'd0};
        vecs[3]  = '{32'h0005_0000, 32'h0000_0000, 4'hF, 1'b0, 1, 0, 32'h0000_0000, 2, 1, 0, 0, 2'b01, 4'd5};
        vecs[4]  = '{32'h0002_0008, 32'hA5A5_5A5A, 4'hF, 1'b1, 0, 0, 32'h0000_0001, 2, 9, 8, 1, 2'b11, 4'd2};
        vecs[5]  = '{32'h0002_0008, 32'h0000_0000, 4'hC, 1'b0, 8, 0, 32'h8765_4321, 1, 9, 8, 0, 2'b11, 4'd2};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 4'hF, 1'b0, 2, 2, 32'h0BAD_0BAD, 2, 3, 2, 0, 2'b10, 4'd0};
        vecs[7]  = '{32'h0001_0000, 32'h7777_7777, 4'h1, 1'b1, 1, 0, 32'h0000_00AA, 1, 2, 1, 0, 2'b10, 4'd0};
        vecs[8]  = '{32'h0002_0000, 32'h0000_0000, 4'hF, 1'b0, 1, 1, 32'h0000_0000, 2, 2, 1, 0, 2'b10, 4'd2};
        vecs[9]  = '{32'h0003_0000, 32'h0000_0000, 4'hF, 1'b1, 1, 0, 32'h0000_0000, 2, 1, 0, 0, 2'b01, 4'd3};
        vecs[10] = '{32'h0002_0000, 32'h0000_0000, 4'hF, 1'b0, 9, 0, 32'h0000_0000, 2, 9, 8, 1, 2'b11, 4'd2};

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset_release");

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            config_slave(int'(vecs[i].adr[LOW +: IW]), vecs[i].delay, vecs[i].mode, vecs[i].rdata);
            run_txn(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, o);
            check_obs($sformatf("vec%0d", i), o, vecs[i].e_resp, vecs[i].e_lat,
                      vecs[i].e_str, vecs[i].e_tmo, vecs[i].rdata, vecs[i].e_kind, vecs[i].e_idx);
        end
        exp_kind = 2'b11; exp_idx = 4'd2;

        // Master abort in the third strobe cycle
        config_slave(1, 0, 0, 32'h5555_AAAA);
        m_adr = 32'h0001_0000; m_dat = '0; m_sel = 4'hF; m_we = 1'b0;
        m_cyc = 1'b1; m_stb = 1'b1;
        repeat (3) begin
            @(negedge clk);
            slave_update();
        end
        chk("abort.stb_before", {s_cyc, s_stb}, {3'b010, 3'b010});
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        slave_update();
        chk("abort.stb_dropped", {s_cyc, s_stb}, '0);
        seen = (m_ack || m_err || tmo) ? 1 : 0;
        repeat (10) begin
            @(negedge clk);
            slave_update();
            if (m_ack || m_err || tmo) seen++;
        end
        chk("abort.no_resp", seen, 0);
        chk("abort.err_kind", ekind, exp_kind);
        chk("abort.err_idx", eidx, exp_idx);
        config_slave(0, 1, 0, 32'h0F0F_0F0F);
        run_txn(32'h0000_0020, 32'h0, 4'hF, 1'b0, o);
        check_obs("after_abort", o, 1, 2, 1, 0, 32'h0F0F_0F0F, exp_kind, exp_idx);

        // Randomized transactions against the reference model
        noise_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] adr;
            logic [DW-1:0] rd;
            int idx, d, md, e_resp, e_lat, e_str, e_tmo;
            idx = $urandom_range(0, 4);
            d   = $urandom_range(0, 10);
            md  = $urandom_range(0, 2);
            rd  = $urandom;
            adr = $urandom;
            adr[LOW +: IW] = IW'(idx);
            config_slave(idx, d, md, rd);
            if (idx >= NP) begin
                e_resp = 2; e_lat = 1; e_str = 0; e_tmo = 0;
                exp_kind = 2'b01; exp_idx = IW'(idx);
            end else if (d >= 1 && d <= TO) begin
                e_resp = (md == 0) ? 1 : 2; e_lat = d + 1; e_str = d; e_tmo = 0;
                if (md != 0) begin
                    exp_kind = 2'b10; exp_idx = IW'(idx);
                end
            end else begin
                e_resp = 2; e_lat = TO + 1; e_str = TO; e_tmo = 1;
                exp_kind = 2'b11; exp_idx = IW'(idx);
            end
            run_txn(adr, DW'($urandom), SW'($urandom), 1'($urandom_range(0, 1)), o);
            check_obs($sformatf("rand%0d", t), o, e_resp, e_lat, e_str, e_tmo, rd, exp_kind, exp_idx);
        end
        noise_en = 1'b0;
        s_ack = '0; s_err = '0;

        // Reset asserted in the middle of an ACTIVE transaction
        config_slave(2, 0, 0, 32'h0);
        m_adr = 32'h0002_0004; m_dat = 32'h1357_9BDF; m_sel = 4'hF; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1;
        repeat (2) begin
            @(negedge clk);
            slave_update();
        end
        chk("rst_mid.stb_before", s_stb, 3'b100);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            slave_update();
            if (m_ack || m_err || tmo || s_stb != '0) seen++;
        end
        chk("rst_mid.quiet", seen, 0);
        config_slave(1, 1, 0, 32'h2468_ACE0);
        run_txn(32'h0001_0008, 32'h0, 4'hF, 1'b0, o);
        check_obs("after_rst", o, 1, 2, 1, 0, 32'h2468_ACE0, 2'b00, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_bus_splitter_wd.md
# wb_bus_splitter_wd

Parametrised Wishbone B4 classic 1-to-N bus splitter with registered slave-side outputs, a per-transaction watchdog and error reporting, placed between the Caravel Wishbone slave port and the user peripherals (AES, SHA256, PIC, and later additions). It is the next generation of the combinational splitter:
- decodes a configurable address field;
- raises a bus error for unmapped peripheral indices;
- aborts and errors any transaction whose slave fails to respond within `TIMEOUT_CYCLES`;
- exposes the last error source for firmware diagnosis.

## Interface
- `NUM_PERIPHERALS`, 4: number of slave ports, 1..16.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `SEL_WIDTH`, 4: byte-select width.
- `ADDR_SEL_LOW_BIT`, 16: lowest address bit of the peripheral index field.
- `IDX_W`, 4: width of the index field, `adr[ADDR_SEL_LOW_BIT +: IDX_W]`.
- `TIMEOUT_CYCLES`, 255: maximum slave strobe cycles; 0 disables the watchdog.

Ports:
- `wb_clk_i`  in  1  single clock; all logic on the rising edge.
- `wb_rst_n`  in  1  reset, synchronous, active-low.
- `m_wb_adr_i`, `m_wb_dat_i`, `m_wb_sel_i`, `m_wb_we_i`, `m_wb_cyc_i`, `m_wb_stb_i`  in  `ADDR_WIDTH`/`DATA_WIDTH`/`SEL_WIDTH`/1/1/1  master request.
- `m_wb_dat_o`  out  `DATA_WIDTH`  read data; 0 except in the ack cycle.
- `m_wb_ack_o`, `m_wb_err_o`  out  1  one-cycle response pulses, mutually exclusive.
- `s_wb_cyc_o`, `s_wb_stb_o`, `s_wb_we_o`  out  `NUM_PERIPHERALS`  per-slave controls.
- `s_wb_sel_o`  out  `NUM_PERIPHERALS*SEL_WIDTH`  per-slave byte selects, slice k = `[k*SEL_WIDTH +: SEL_WIDTH]`.
- `s_wb_adr_o`  out  `NUM_PERIPHERALS*ADDR_WIDTH`  per-slave addresses, slice k.
- `s_wb_dat_o`  out  `NUM_PERIPHERALS*DATA_WIDTH`  per-slave write data, slice k.
- `s_wb_dat_i`  in  `NUM_PERIPHERALS*DATA_WIDTH`  per-slave read data.
- `s_wb_ack_i`, `s_wb_err_i`  in  `NUM_PERIPHERALS`  per-slave responses.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.
- `err_idx_o`  out  `IDX_W`  index of the last errored transaction, sticky.
- `err_kind_o`  out  2  kind of the last error: 00 none, 01 unmapped, 10 slave err, 11 timeout; sticky.

## Operation
- States: IDLE, ACTIVE, RESP.
- **IDLE, accept:** when `m_wb_cyc_i & m_wb_stb_i`, latch `adr`, `dat`, `sel`, `we` and `idx`.
  - `idx >= NUM_PERIPHERALS` → go to RESP with error, kind 01. No slave is strobed.
  - Otherwise → go to ACTIVE and clear the watchdog counter.
- **ACTIVE:** only slave `idx` has `cyc`/`stb` = 1, driven from the latched request.
  - All other slave `cyc`/`stb`/`we`/`sel` are 0.
  - All `adr`/`dat` slices carry the latched values; this broadcast is allowed.
- **Leaving ACTIVE**, priority highest first:
  1. `!m_wb_cyc_i` (master abort) → IDLE, no response, error registers unchanged.
  2. `s_wb_err_i[idx]` → RESP with error, kind 10.
  3. `s_wb_ack_i[idx]` → RESP with ack; capture `s_wb_dat_i` slice `idx`.
  4. Watchdog expiry (counter == `TIMEOUT_CYCLES-1`, `TIMEOUT_CYCLES != 0`) → RESP with error, kind 11, `timeout_o` pulse.
  5. Otherwise increment the counter.
- Acks and errs from non-selected slaves are ignored.
- **RESP:** drive exactly one of `m_wb_ack_o` / `m_wb_err_o` for one cycle, then go to IDLE.
  - Slave `cyc`/`stb` are 0 in RESP.
- **Error registers:** every error response loads `err_idx_o` and `err_kind_o`. Successful transactions do not clear them; only reset does.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates rather than wraps.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE.
- Reset asserted mid-transaction: next edge forces IDLE, drops all slave strobes, emits no response.
- **Mapped access:** master request sampled at edge N.
  - Slave strobe is high from N+1.
  - Slave acks in the cycle sampled at edge M.
  - Slave strobe drops at M+1; `m_wb_ack_o` and data are high during M+1.
  - The state is back in IDLE at M+2.
- Minimum master latency is 2 cycles (zero-wait slave).
- **Unmapped access:** `m_wb_err_o` is high during N+1.
- **Timeout:** the slave sees exactly `TIMEOUT_CYCLES` strobe cycles; `m_wb_err_o` and `timeout_o` are high in the following cycle.
- Ack at the same edge as watchdog expiry: the ack wins, no timeout.
- The master must deassert `stb` after a response, per Wishbone classic. A request still held in the IDLE cycle after RESP is treated as a new transaction.

## Test plan
- **Write then read to peripheral 1**, address 0x0001_0004, slave acks on its first strobe cycle:
  - slave 1 sees `we`=1, `dat`=0xDEADBEEF, `sel`=0xF;
  - `m_wb_ack_o` is high 2 cycles after the request edge;
  - the read returns the slave data; no other `s_wb_cyc_o` bit is ever set.
- **Unmapped index**, `NUM_PERIPHERALS`=3, address 0x0005_0000:
  - `m_wb_err_o` pulses 1 cycle after the request;
  - no slave strobes;
  - `err_idx_o`=5, `err_kind_o`=01.
- **Silent slave 2**, `TIMEOUT_CYCLES`=8:
  - `s_wb_stb_o[2]` is high exactly 8 cycles;
  - then `m_wb_err_o` and `timeout_o` pulse;
  - `err_kind_o`=11, `err_idx_o`=2.
  - Repeat with the ack in strobe cycle 8: the master gets an ack, no timeout.
- **Slave 0 raises `err` and `ack` together:**
  - `m_wb_err_o`=1, `m_wb_ack_o`=0, `err_kind_o`=10.
  - A following good access leaves `err_kind_o`=10.
- **Master drops `cyc` in ACTIVE cycle 3:** slave strobe drops next edge, no ack or err, state IDLE.
- **`wb_rst_n`=0 during ACTIVE:** all outputs 0 next edge; `err_kind_o`=00.
